sudoku_grid_ctrl: RTL and testbench



---
 rtl/sudoku_grid_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sudoku_grid_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_grid_ctrl.sv
`default_nettype none
// ============================================================================
// sudoku_grid_ctrl : loads 81 puzzle digits into the cell array, then runs
//                    update passes until solved, stalled, or out of passes.
// Revision: 1.0
// ============================================================================
module sudoku_grid_ctrl #(
    parameter int         MAX_PASS   = 9,
    parameter logic [3:0] CMD_LOAD   = 4'h0,
    parameter logic [3:0] CMD_UPDATE = 4'h1,
    parameter logic [3:0] CMD_NOP    = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [3:0] in_digit,
    output logic       in_ready,
    output logic [6:0] cell_sel,
    output logic [3:0] cell_cmd,
    output logic [3:0] cell_data,
    output logic       cell_data_rdy,
    input  logic       cell_solved,
    output logic       busy,
    output logic       done,
    output logic       success,
    output logic       bad_digit,
    output logic [3:0] pass_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PASS  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [6:0] LAST_CELL  = 7'd80;
    localparam logic [6:0] NUM_CELLS  = 7'd81;
    localparam logic [3:0] PASS_LIMIT = 4'(MAX_PASS);
    localparam logic [3:0] PASS_SAT   = 4'hF;

    state_t     state_q, state_d;
    logic [6:0] idx_q, idx_d;
    logic [6:0] solved_q, solved_d;
    logic [6:0] prev_q, prev_d;
    logic [3:0] pass_cnt_q, pass_cnt_d;
    logic       bad_digit_q, bad_digit_d;
    logic       success_q, success_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 7'd0;
            solved_q    <= 7'd0;
            prev_q      <= 7'd0;
            pass_cnt_q  <= 4'd0;
            bad_digit_q <= 1'b0;
            success_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            solved_q    <= solved_d;
            prev_q      <= prev_d;
            pass_cnt_q  <= pass_cnt_d;
            bad_digit_q <= bad_digit_d;
            success_q   <= success_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        solved_d      = solved_q;
        prev_d        = prev_q;
        pass_cnt_d    = pass_cnt_q;
        bad_digit_d   = bad_digit_q;
        success_d     = success_q;
        in_ready      = 1'b0;
        cell_sel      = idx_q;
        cell_cmd      = CMD_NOP;
        cell_data     = 4'd0;
        cell_data_rdy = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    idx_d       = 7'd0;
                    solved_d    = 7'd0;
                    prev_d      = 7'd0;
                    pass_cnt_d  = 4'd0;
                    bad_digit_d = 1'b0;
                    success_d   = 1'b0;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cell_cmd      = CMD_LOAD;
                    cell_data_rdy = 1'b1;
                    // Out-of-range digits are loaded as blanks and flagged.
                    if (in_digit > 4'd9) begin
                        bad_digit_d = 1'b1;
                    end else begin
                        cell_data = in_digit;
                    end
                    if (idx_q == LAST_CELL) begin
                        state_d = S_PASS;
                        idx_d   = 7'd0;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            S_PASS: begin
                cell_cmd      = CMD_UPDATE;
                cell_data_rdy = 1'b1;
                solved_d      = solved_q + {6'd0, cell_solved};
                if (idx_q == LAST_CELL) begin
                    state_d = S_CHECK;
                    idx_d   = 7'd0;
                    if (pass_cnt_q != PASS_SAT) begin
                        pass_cnt_d = pass_cnt_q + 4'd1;
                    end
                end else begin
                    idx_d = idx_q + 7'd1;
                end
            end
            S_CHECK: begin
                if (solved_q == NUM_CELLS) begin
                    state_d   = S_DONE;
                    success_d = 1'b1;
                end else if ((solved_q == prev_q) || (pass_cnt_q == PASS_LIMIT)) begin
                    state_d   = S_DONE;
                    success_d = 1'b0;
                end else begin
                    state_d  = S_PASS;
                    prev_d   = solved_q;
                    solved_d = 7'd0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flops track the state being entered so they align with it.
        busy_d = (state_d == S_LOAD) || (state_d == S_PASS) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign success   = success_q;
    assign bad_digit = bad_digit_q;
    assign pass_cnt  = pass_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sudoku_grid_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sudoku_grid_ctrl : directed self-checking bench for sudoku_grid_ctrl.
// Revision: 1.0
// ============================================================================
module tb_sudoku_grid_ctrl;

    localparam logic [3:0] C_LOAD = 4'h0;
    localparam logic [3:0] C_UPD  = 4'h1;
    localparam logic [3:0] C_NOP  = 4'hF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_digit = 4'd0;
    logic       in_ready;
    logic [6:0] cell_sel;
    logic [3:0] cell_cmd;
    logic [3:0] cell_data;
    logic       cell_data_rdy;
    logic       cell_solved;
    logic       busy, done, success, bad_digit;
    logic [3:0] pass_cnt;

    int checks = 0;
    int errors = 0;

    int mode = 0;
    int upd_cnt;
    int model_pass;
    int load_cnt;
    int load_err;
    logic [3:0] ld_data [81];

    sudoku_grid_ctrl #(
        .MAX_PASS   (4),
        .CMD_LOAD   (C_LOAD),
        .CMD_UPDATE (C_UPD),
        .CMD_NOP    (C_NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_digit      (in_digit),
        .in_ready      (in_ready),
        .cell_sel      (cell_sel),
        .cell_cmd      (cell_cmd),
        .cell_data     (cell_data),
        .cell_data_rdy (cell_data_rdy),
        .cell_solved   (cell_solved),
        .busy          (busy),
        .done          (done),
        .success       (success),
        .bad_digit     (bad_digit),
        .pass_cnt      (pass_cnt)
    );

    always #5 clk = ~clk;

    // Cell array model: how many cells report solved depends on the pass number.
    always_comb begin
        model_pass = upd_cnt / 81;
        case (mode)
            0:       cell_solved = 1'b1;
            1:       cell_solved = (int'(cell_sel) < (model_pass + 1) * 27);
            2:       cell_solved = (int'(cell_sel) < 40);
            3:       cell_solved = (int'(cell_sel) <= model_pass);
            default: cell_solved = 1'b0;
        endcase
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            upd_cnt <= 0;
        else if (start && !busy)
            upd_cnt <= 0;
        else if (cell_data_rdy && cell_cmd == C_UPD)
            upd_cnt <= upd_cnt + 1;
    end

    always @(negedge clk) begin
        if (start && !busy) begin
            load_cnt <= 0;
            load_err <= 0;
            for (int i = 0; i < 81; i++) ld_data[i] <= 4'bxxxx;
        end else if (cell_data_rdy && cell_cmd == C_LOAD) begin
            if ((int'(cell_sel) != load_cnt) || !in_ready || !in_valid)
                load_err <= load_err + 1;
            if (cell_sel < 7'd81)
                ld_data[cell_sel] <= cell_data;
            load_cnt <= load_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] stim_digit(input int i, input bit bad5);
        if (bad5 && i == 5) return 4'd12;
        return 4'(i % 10);
    endfunction

    function automatic logic [3:0] exp_digit(input int i, input bit bad5);
        if (bad5 && i == 5) return 4'd0;
        return 4'(i % 10);
    endfunction

    task automatic start_job();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Returns at #1 after the edge that takes the last digit.
    task automatic feed(input string tag, input bit gap, input bit bad5);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < 81 && cyc < 1000) begin
            in_valid = gap ? (cyc % 2 == 0) : 1'b1;
            in_digit = stim_digit(i, bad5);
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_digit = 4'd0;
        check({tag, "_feed_count"}, i, 81);
    endtask

    task automatic check_load(input string tag, input bit bad5);
        int mm;
        mm = 0;
        for (int i = 0; i < 81; i++)
            if (ld_data[i] !== exp_digit(i, bad5)) mm++;
        check({tag, "_load_strobes"}, load_cnt, 81);
        check({tag, "_load_order"}, load_err, 0);
        check({tag, "_load_data"}, mm, 0);
    endtask

    task automatic run_job(input string tag, input int md, input bit gap, input bit bad5,
                           input int mid_start, input int exp_pass, input bit exp_succ);
        int  cyc;
        bit  seen;
        logic busy1;
        mode = md;
        start_job();
        feed(tag, gap, bad5);
        check_load(tag, bad5);
        cyc = 0;
        seen = 0;
        busy1 = 1'b0;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == mid_start);
            if (cyc == 1) busy1 = busy;
            if (done) seen = 1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_busy_in_pass"}, busy1, 1);
        check({tag, "_done_cycle"}, cyc, exp_pass * 82 + 1);
        check({tag, "_success"}, success, exp_succ);
        check({tag, "_pass_cnt"}, pass_cnt, exp_pass);
        check({tag, "_bad_digit"}, bad_digit, bad5);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_update_strobes"}, upd_cnt, 81 * exp_pass);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_held_success"}, success, exp_succ);
        check({tag, "_held_pass_cnt"}, pass_cnt, exp_pass);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_cell_sel"}, cell_sel, 0);
        check({tag, "_cell_cmd"}, cell_cmd, C_NOP);
        check({tag, "_cell_data"}, cell_data, 0);
        check({tag, "_cell_rdy"}, cell_data_rdy, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_success"}, success, 0);
        check({tag, "_bad_digit"}, bad_digit, 0);
        check({tag, "_pass_cnt"}, pass_cnt, 0);
    endtask

    initial begin
        int  n;
        bit  hit;

        #12;
        check_reset_values("por");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        // Back-to-back load, everything solved in one pass.
        run_job("jobA", 0, 1'b0, 1'b0, 0, 1, 1'b1);
        // Gapped load stream.
        run_job("jobB", 0, 1'b1, 1'b0, 0, 1, 1'b1);
        // Solved on third pass; start pulsed mid-pass must be ignored.
        run_job("jobC", 1, 1'b0, 1'b0, 100, 3, 1'b1);
        // Stuck at 40 cells: no progress on pass 2.
        run_job("jobD", 2, 1'b0, 1'b0, 0, 2, 1'b0);
        // One more cell per pass until MAX_PASS=4 runs out; bad digit at cell 5.
        run_job("jobE", 3, 1'b0, 1'b1, 0, 4, 1'b0);
        check("jobE_cell5_data", ld_data[5], 4'd0);

        // Reset in the middle of a pass.
        mode = 0;
        start_job();
        feed("jobF", 1'b0, 1'b1);
        n = 0;
        hit = 0;
        while (!hit && n < 200) begin
            @(negedge clk);
            n++;
            if (cell_data_rdy && cell_cmd == C_UPD && cell_sel == 7'd40) hit = 1;
        end
        check("jobF_reached_idx40", hit, 1);
        check("jobF_bad_before_rst", bad_digit, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("postrst");

        run_job("jobG", 0, 1'b0, 1'b0, 0, 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
